// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
// Imported by the sequencer top and its edge skew lines.
package systolic_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_READOUT
   } state_e;

   // Cycles for the last operand pair to cross the grid corner to corner.
   function automatic int drain_len(input int n);
      return 2 * n - 1;
   endfunction

   function automatic int res_w(input int dw);
      return 2 * dw;
   endfunction

   // One counter serves both FEED (up to K-1) and DRAIN (up to 2N-2).
   function automatic int cnt_w(input int kw, input int n);
      int dcw;
      dcw = $clog2(2 * n);
      return (kw > dcw) ? kw : dcw;
   endfunction

endpackage

// File: rtl/systolic_ctrl_skew_line.sv
// Zero-reset delay line of DEPTH stages; DEPTH=0 is a plain wire.
// Staggers one operand lane so wavefronts meet on the grid diagonal.
module skew_line
   import systolic_pkg::*;
#(
   parameter int DEPTH = 1,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] d_i,
   output logic [DW-1:0] q_o
);

   if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q_o = d_i;
   end else begin : g_delay
      logic [DW-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
         end else begin
            stage_q[0] <= d_i;
            for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
         end
      end

      assign q_o = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic MAC array: clear,
// feed K skewed operand slices, drain, then stream result rows out.
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 32,
   parameter int KW = 8,
   localparam int RW = (N > 1) ? $clog2(N) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [KW-1:0]         k_len,
   output logic                  busy,
   output logic                  done,
   output logic                  arr_clr_n,
   output logic                  op_rd_en,
   output logic [KW-1:0]         op_rd_k,
   input  logic [N*DW-1:0]       a_rd_data,
   input  logic [N*DW-1:0]       b_rd_data,
   output logic [N*DW-1:0]       west_vec,
   output logic [N*DW-1:0]       north_vec,
   input  logic [N*N*2*DW-1:0]   result_flat,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [RW-1:0]         res_row,
   output logic [N*2*DW-1:0]     res_data
);

   localparam int PW = res_w(DW);
   localparam int DL = drain_len(N);
   localparam int CW = cnt_w(KW, N);

   state_e        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] row_q, row_d;
   logic          done_q, done_d;
   logic          clr_n_q;
   logic          rd_vld_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         cnt_q    <= '0;
         row_q    <= '0;
         done_q   <= 1'b0;
         clr_n_q  <= 1'b1;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         cnt_q    <= cnt_d;
         row_q    <= row_d;
         done_q   <= done_d;
         clr_n_q  <= (state_d != S_CLEAR);
         rd_vld_q <= (state_q == S_FEED);
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               k_d     = k_len;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            row_d   = '0;
            state_d = (k_q != '0) ? S_FEED : S_READOUT;
         end
         S_FEED: begin
            if (cnt_q == CW'(k_q) - CW'(1)) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == CW'(DL - 1)) begin
               cnt_d   = '0;
               state_d = S_READOUT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_READOUT: begin
            if (res_ready) begin
               if (row_q == RW'(N - 1)) begin
                  row_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign arr_clr_n = clr_n_q;
   assign op_rd_en  = (state_q == S_FEED);
   assign op_rd_k   = op_rd_en ? cnt_q[KW-1:0] : '0;
   assign res_valid = (state_q == S_READOUT);
   assign res_row   = row_q;
   assign res_data  = res_valid ? result_flat[int'(row_q)*N*PW +: N*PW] : '0;

   // Buffer data is only trusted the cycle after a read; otherwise inject zeros.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] a_lane, b_lane;
      assign a_lane = rd_vld_q ? a_rd_data[i*DW +: DW] : '0;
      assign b_lane = rd_vld_q ? b_rd_data[i*DW +: DW] : '0;

      skew_line #(.DEPTH(i), .DW(DW)) u_west (
         .clk (clk),
         .rst (rst),
         .d_i (a_lane),
         .q_o (west_vec[i*DW +: DW])
      );

      skew_line #(.DEPTH(i), .DW(DW)) u_north (
         .clk (clk),
         .rst (rst),
         .d_i (b_lane),
         .q_o (north_vec[i*DW +: DW])
      );
   end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl (N=2) with a behavioural operand buffer and PE grid.
// Expected result rows are queued at stimulus time and checked by a monitor.
module tb_systolic_ctrl;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int KW = 8;
   localparam int PW = 2 * DW;
   localparam int RW = 1;
   localparam int EW = RW + N * PW;

   logic                clk;
   logic                rst;
   logic                start;
   logic [KW-1:0]       k_len;
   logic                busy;
   logic                done;
   logic                arr_clr_n;
   logic                op_rd_en;
   logic [KW-1:0]       op_rd_k;
   logic [N*DW-1:0]     a_rd_data;
   logic [N*DW-1:0]     b_rd_data;
   logic [N*DW-1:0]     west_vec;
   logic [N*DW-1:0]     north_vec;
   logic [N*N*PW-1:0]   result_flat;
   logic                res_valid;
   logic                res_ready;
   logic [RW-1:0]       res_row;
   logic [N*PW-1:0]     res_data;

   systolic_ctrl #(.N(N), .DW(DW), .KW(KW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .k_len       (k_len),
      .busy        (busy),
      .done        (done),
      .arr_clr_n   (arr_clr_n),
      .op_rd_en    (op_rd_en),
      .op_rd_k     (op_rd_k),
      .a_rd_data   (a_rd_data),
      .b_rd_data   (b_rd_data),
      .west_vec    (west_vec),
      .north_vec   (north_vec),
      .result_flat (result_flat),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_row     (res_row),
      .res_data    (res_data)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // operand buffers: A[i][k], B[k][j]; junk returned when not read
   logic [DW-1:0] a_mem [N][16];
   logic [DW-1:0] b_mem [16][N];

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (op_rd_en) begin
            a_rd_data[i*DW +: DW] <= a_mem[i][op_rd_k[3:0]];
            b_rd_data[i*DW +: DW] <= b_mem[op_rd_k[3:0]][i];
         end else begin
            a_rd_data[i*DW +: DW] <= 32'hDEAD_BEEF;
            b_rd_data[i*DW +: DW] <= 32'hCAFE_F00D;
         end
      end
   end

   // output-stationary PE grid, cleared by arr_clr_n
   logic [DW-1:0] pe_w_q [N][N];
   logic [DW-1:0] pe_n_q [N][N];
   logic [PW-1:0] acc_q  [N][N];

   function automatic logic [DW-1:0] w_in(input int r, input int c);
      if (c == 0) return west_vec[r*DW +: DW];
      return pe_w_q[r][c-1];
   endfunction

   function automatic logic [DW-1:0] n_in(input int r, input int c);
      if (r == 0) return north_vec[c*DW +: DW];
      return pe_n_q[r-1][c];
   endfunction

   always @(posedge clk or negedge arr_clr_n) begin
      if (!arr_clr_n) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               pe_w_q[r][c] <= '0;
               pe_n_q[r][c] <= '0;
               acc_q[r][c]  <= '0;
            end
      end else begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               acc_q[r][c]  <= acc_q[r][c] + PW'(w_in(r, c)) * PW'(n_in(r, c));
               pe_w_q[r][c] <= w_in(r, c);
               pe_n_q[r][c] <= n_in(r, c);
            end
      end
   end

   always_comb begin
      result_flat = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            result_flat[(r*N+c)*PW +: PW] = acc_q[r][c];
   end

   // scoreboard state
   logic [EW-1:0] exp_q [$];
   int n_checks = 0;
   int n_pass   = 0;
   int clr_cnt  = 0;
   int rd_cnt   = 0;
   int done_cnt = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [EW-1:0] beat(input logic r, input logic [PW-1:0] c0,
                                          input logic [PW-1:0] c1);
      return {r, c1, c0};
   endfunction

   // driver: one operation, with optional row-0 stall, edge capture and ignored start
   task automatic run_op(input int k, input int stall, input bit cap, input bit poke);
      int stall_left;
      int off;
      int clr0, rd0, dn0;
      bit poked, got_done;
      logic [DW-1:0] w0 [8];
      logic [DW-1:0] w1 [8];
      logic [DW-1:0] n1 [8];
      int exp_w0 [8];
      int exp_w1 [8];
      int exp_n1 [8];
      exp_w0 = '{0, 1, 2, 0, 0, 0, 0, 0};
      exp_w1 = '{0, 0, 3, 4, 0, 0, 0, 0};
      exp_n1 = '{0, 0, 6, 8, 0, 0, 0, 0};
      stall_left = stall;
      off = -1;
      poked = 1'b0;
      got_done = 1'b0;
      clr0 = clr_cnt;
      rd0 = rd_cnt;
      dn0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      k_len = KW'(k);
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
         if (res_valid && res_row == 1'b0 && stall_left > 0) begin
            res_ready = 1'b0;
            stall_left--;
         end else begin
            res_ready = 1'b1;
         end
         if (poke && res_valid && !poked) begin
            start = 1'b1;
            k_len = 8'd1;
            poked = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (cap) begin
            if (off < 0 && op_rd_en) off = 0;
            if (off >= 0 && off < 8) begin
               w0[off] = west_vec[0 +: DW];
               w1[off] = west_vec[DW +: DW];
               n1[off] = north_vec[DW +: DW];
               off++;
            end
         end
         if (done) got_done = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      if (!got_done) check("run_timeout", 0, 1);
      res_ready = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_done", busy, 0);
      check("queue_drained", exp_q.size(), 0);
      check("clr_low_cycles", clr_cnt - clr0, 1);
      check("rd_strobes", rd_cnt - rd0, k);
      check("done_pulses", done_cnt - dn0, 1);
      if (cap) begin
         for (int i = 0; i < 8; i++) begin
            check($sformatf("west0_F+%0d", i), w0[i], exp_w0[i]);
            check($sformatf("west1_F+%0d", i), w1[i], exp_w1[i]);
            check($sformatf("north1_F+%0d", i), n1[i], exp_n1[i]);
         end
      end
   endtask

   task automatic load_main();
      a_mem[0][0] = 1; a_mem[0][1] = 2;
      a_mem[1][0] = 3; a_mem[1][1] = 4;
      b_mem[0][0] = 5; b_mem[0][1] = 6;
      b_mem[1][0] = 7; b_mem[1][1] = 8;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_clr_n"}, arr_clr_n, 1);
      check({tag, "_rd_en"}, op_rd_en, 0);
      check({tag, "_rd_k"}, op_rd_k, 0);
      check({tag, "_west"}, west_vec, 0);
      check({tag, "_north"}, north_vec, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_res_row"}, res_row, 0);
      check({tag, "_res_data"}, res_data, 0);
   endtask

   initial begin
      int busy_hi;
      int clr0;
      bit found;
      rst = 1'b1;
      start = 1'b0;
      k_len = '0;
      res_ready = 1'b1;

      // monitor: compares every presented beat with the queue head
      fork
         forever begin
            @(negedge clk);
            if (!arr_clr_n) clr_cnt++;
            if (op_rd_en) rd_cnt++;
            if (done) begin
               done_cnt++;
               check("done_after_last", exp_q.size(), 0);
            end
            if (res_valid) begin
               if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
               else begin
                  check($sformatf("beat_row%0d", res_row), {res_row, res_data}, exp_q[0]);
                  if (res_ready) void'(exp_q.pop_front());
               end
            end
         end
      join_none

      // reset and idle
      #2 rst = 1'b0;
      #1 check_reset_outputs("reset");
      #20 rst = 1'b1;
      busy_hi = 0;
      clr0 = clr_cnt;
      repeat (10) begin
         @(negedge clk);
         if (busy) busy_hi++;
      end
      check("idle_busy_cycles", busy_hi, 0);
      check("idle_no_clear", clr_cnt - clr0, 0);

      // main run, with an ignored start (k_len=1) issued during readout
      load_main();
      exp_q.push_back(beat(1'b0, 64'd19, 64'd22));
      exp_q.push_back(beat(1'b1, 64'd43, 64'd50));
      run_op(2, 0, 1'b1, 1'b1);

      // re-issued start: A = I, B = diag(2,3); no carry-over
      a_mem[0][0] = 1; a_mem[0][1] = 0;
      a_mem[1][0] = 0; a_mem[1][1] = 1;
      b_mem[0][0] = 2; b_mem[0][1] = 0;
      b_mem[1][0] = 0; b_mem[1][1] = 3;
      exp_q.push_back(beat(1'b0, 64'd2, 64'd0));
      exp_q.push_back(beat(1'b1, 64'd0, 64'd3));
      run_op(2, 0, 1'b0, 1'b0);

      // backpressure on row 0
      load_main();
      exp_q.push_back(beat(1'b0, 64'd19, 64'd22));
      exp_q.push_back(beat(1'b1, 64'd43, 64'd50));
      run_op(2, 3, 1'b0, 1'b0);

      // K = 0
      exp_q.push_back(beat(1'b0, 64'd0, 64'd0));
      exp_q.push_back(beat(1'b1, 64'd0, 64'd0));
      run_op(0, 0, 1'b0, 1'b0);

      // K = 4 operands, abort mid-FEED at k = 1
      for (int k = 0; k < 4; k++) begin
         a_mem[0][k] = DW'(k + 1);
         a_mem[1][k] = DW'(k + 5);
         b_mem[k][0] = DW'(2 * k + 1);
         b_mem[k][1] = DW'(2 * k + 2);
      end
      @(posedge clk); #1;
      start = 1'b1;
      k_len = 8'd4;
      @(posedge clk); #1;
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (op_rd_en && op_rd_k == 8'd1) found = 1'b1;
      end
      check("abort_reached_k1", found, 1);
      #2 rst = 1'b0;
      #1 check_reset_outputs("abort");
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;

      // fresh K = 4 run after abort
      exp_q.push_back(beat(1'b0, 64'd50, 64'd60));
      exp_q.push_back(beat(1'b1, 64'd114, 64'd140));
      run_op(4, 0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
